// File: rtl/display_arbiter_if.sv
// Display bus between the requesting sources and the arbiter that drives the segment controller.
// The master modport is the source/controller side; the slave modport is the arbiter.
interface display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    request;
    logic [16*NUM_REQ-1:0] dataIn;
    logic [4*NUM_REQ-1:0]  pointsIn;
    logic [15:0]           data;
    logic [3:0]            pointEnable;
    logic [NUM_REQ-1:0]    grant;
    logic                  grantValid;
    logic                  switched;

    modport master (
        output request, dataIn, pointsIn,
        input  data, pointEnable, grant, grantValid, switched
    );

    modport slave (
        input  request, dataIn, pointsIn,
        output data, pointEnable, grant, grantValid, switched
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display: fair rotation after a minimum dwell,
// immediate release when the owner withdraws, fully registered outputs.
module display_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic             clock,
    input  logic             reset,
    display_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [15:0]        data_q, data_d;
    logic [3:0]         point_q, point_d;
    logic               switched_q, switched_d;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W:0]     idle_pick;
    logic [IDX_W:0]     next_pick;
    logic               dwell_done;
    logic               owner_req;

    // Returns {found, index} of the first set bit at start, start+1, ... modulo NUM_REQ.
    function automatic logic [IDX_W:0] rr_search(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] result;
        int j;
        result = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) result = {1'b1, IDX_W'(j)};
        end
        return result;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        count_d    = count_q;
        owner_mask = '0;
        owner_mask[owner_q] = 1'b1;
        others     = bus.request & ~owner_mask;
        owner_req  = bus.request[owner_q];
        dwell_done = (count_q == DWELL_LAST);
        idle_pick  = rr_search(bus.request, rr_ptr_q);
        next_pick  = rr_search(others, wrap_inc(owner_q));

        case (state_q)
            ST_IDLE: begin
                if (idle_pick[IDX_W]) begin
                    state_d = ST_OWNED;
                    owner_d = idle_pick[IDX_W-1:0];
                end
            end
            default: begin
                if ((!owner_req || dwell_done) && next_pick[IDX_W]) begin
                    owner_d = next_pick[IDX_W-1:0];
                end else if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (!dwell_done) begin
                    count_d = count_q + 1'b1;
                end
            end
        endcase

        // A fresh owner restarts its dwell and moves the fairness pointer past itself.
        if (state_d == ST_OWNED && (state_q == ST_IDLE || owner_d != owner_q)) begin
            count_d  = '0;
            rr_ptr_d = wrap_inc(owner_d);
        end

        grant_d = '0;
        data_d  = '0;
        point_d = '0;
        if (state_d == ST_OWNED) begin
            grant_d[owner_d] = 1'b1;
            data_d  = bus.dataIn[16*int'(owner_d) +: 16];
            point_d = bus.pointsIn[4*int'(owner_d) +: 4];
        end
        grant_valid_d = |grant_d;
        switched_d    = (grant_d != grant_q);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            count_q       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            data_q        <= '0;
            point_q       <= '0;
            switched_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            data_q        <= data_d;
            point_q       <= point_d;
            switched_q    <= switched_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grantValid  = grant_valid_q;
    assign bus.data        = data_q;
    assign bus.pointEnable = point_q;
    assign bus.switched    = switched_q;
endmodule
